// File: rtl/heart_life_sequencer_pkg.sv
// Shared types for the heart life sequencer: FSM state encoding and frame counter width.
package heart_seq_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    BLINK     = 2'd1,
    SHATTER   = 2'd2,
    GAME_OVER = 2'd3
  } heart_state_t;

  localparam int FRAME_CNT_W = 10;

endpackage

// File: rtl/heart_life_sequencer_if.sv
// Video-timing, game-event and status signals between the game logic and the heart sequencer.
interface heart_life_sequencer_if;

  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        hit_in;
  logic        restart_in;

  logic        frag_rst_out;
  logic        heart_visible_out;
  logic        shatter_active_out;
  logic [3:0]  lives_out;
  logic        game_over_out;
  logic [1:0]  state_out;

  modport master (
    output hcount_in, vcount_in, valid_in, hit_in, restart_in,
    input  frag_rst_out, heart_visible_out, shatter_active_out,
    input  lives_out, game_over_out, state_out
  );

  modport slave (
    input  hcount_in, vcount_in, valid_in, hit_in, restart_in,
    output frag_rst_out, heart_visible_out, shatter_active_out,
    output lives_out, game_over_out, state_out
  );

endinterface

// File: rtl/heart_life_sequencer_frame_tick_gen.sv
// One-cycle frame strobe at the first valid pixel of each frame; shared by frame-stepped sprites.
module frame_tick_gen (
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  output logic        frame_tick
);

  assign frame_tick = valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);

endmodule

// File: rtl/heart_life_sequencer.sv
// Lives/invulnerability/shatter controller feeding the heart fragment-animation stage.
// All outputs are registered; events sampled in one cycle appear on the outputs the next.
module heart_life_sequencer
  import heart_seq_pkg::*;
#(
  parameter int LIVES             = 3,
  parameter int BLINK_FRAMES      = 120,
  parameter int BLINK_PERIOD_LOG2 = 3,
  parameter int SHATTER_FRAMES    = 240
) (
  input  logic                   clk,
  input  logic                   rst,
  heart_life_sequencer_if.slave  bus
);

  localparam logic [3:0]             LIVES_INIT   = 4'(LIVES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_LAST   = FRAME_CNT_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] SHATTER_LAST = FRAME_CNT_W'(SHATTER_FRAMES - 1);

  heart_state_t           state_q, state_d;
  logic [3:0]             lives_q, lives_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   frag_rst_q, frag_rst_d;
  logic                   heart_visible_q, heart_visible_d;
  logic                   shatter_active_q, shatter_active_d;
  logic                   game_over_q, game_over_d;
  logic                   hit_q, hit_d;

  logic                   frame_tick_s;
  logic                   hit_rise_s;
  logic [FRAME_CNT_W-1:0] frame_cnt_inc_s;

  frame_tick_gen u_frame_tick_gen (
    .hcount_in  (bus.hcount_in),
    .vcount_in  (bus.vcount_in),
    .valid_in   (bus.valid_in),
    .frame_tick (frame_tick_s)
  );

  // Next-state logic; restart outranks hits and frame ticks in every state.
  always_comb begin
    hit_d            = bus.hit_in;
    hit_rise_s       = bus.hit_in & ~hit_q;
    frame_cnt_inc_s  = frame_cnt_q + 10'd1;

    state_d          = state_q;
    lives_d          = lives_q;
    frame_cnt_d      = frame_cnt_q;
    frag_rst_d       = frag_rst_q;
    heart_visible_d  = heart_visible_q;
    shatter_active_d = shatter_active_q;
    game_over_d      = game_over_q;

    if (bus.restart_in) begin
      state_d          = ALIVE;
      lives_d          = LIVES_INIT;
      frame_cnt_d      = 10'd0;
      frag_rst_d       = 1'b1;
      heart_visible_d  = 1'b1;
      shatter_active_d = 1'b0;
      game_over_d      = 1'b0;
    end else begin
      case (state_q)
        ALIVE: begin
          // A hit in the same cycle as a frame tick wins; the counter restarts at zero.
          if (hit_rise_s) begin
            frame_cnt_d = 10'd0;
            if (lives_q > 4'd1) begin
              state_d         = BLINK;
              lives_d         = lives_q - 4'd1;
              heart_visible_d = 1'b1;
              frag_rst_d      = 1'b1;
            end else begin
              state_d          = SHATTER;
              lives_d          = 4'd0;
              frag_rst_d       = 1'b0;
              heart_visible_d  = 1'b0;
              shatter_active_d = 1'b1;
            end
          end else begin
            heart_visible_d = 1'b1;
            frag_rst_d      = 1'b1;
          end
        end
        BLINK: begin
          if (frame_tick_s) begin
            if (frame_cnt_q == BLINK_LAST) begin
              state_d         = ALIVE;
              frame_cnt_d     = 10'd0;
              heart_visible_d = 1'b1;
            end else begin
              frame_cnt_d     = frame_cnt_inc_s;
              heart_visible_d = ~frame_cnt_inc_s[BLINK_PERIOD_LOG2];
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        SHATTER: begin
          if (frame_tick_s) begin
            if (frame_cnt_q == SHATTER_LAST) begin
              state_d          = GAME_OVER;
              frame_cnt_d      = 10'd0;
              shatter_active_d = 1'b0;
              game_over_d      = 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_inc_s;
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end
        GAME_OVER: begin
          frag_rst_d      = 1'b0;
          heart_visible_d = 1'b0;
          game_over_d     = 1'b1;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ALIVE;
      lives_q          <= LIVES_INIT;
      frame_cnt_q      <= 10'd0;
      frag_rst_q       <= 1'b1;
      heart_visible_q  <= 1'b1;
      shatter_active_q <= 1'b0;
      game_over_q      <= 1'b0;
      hit_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      lives_q          <= lives_d;
      frame_cnt_q      <= frame_cnt_d;
      frag_rst_q       <= frag_rst_d;
      heart_visible_q  <= heart_visible_d;
      shatter_active_q <= shatter_active_d;
      game_over_q      <= game_over_d;
      hit_q            <= hit_d;
    end
  end

  assign bus.state_out          = state_q;
  assign bus.lives_out          = lives_q;
  assign bus.frag_rst_out       = frag_rst_q;
  assign bus.heart_visible_out  = heart_visible_q;
  assign bus.shatter_active_out = shatter_active_q;
  assign bus.game_over_out      = game_over_q;

endmodule

// File: tb/tb_heart_life_sequencer.sv
// Scoreboard bench for heart_life_sequencer: directed stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_heart_life_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  heart_life_sequencer_if bus();

  heart_life_sequencer #(
    .LIVES             (3),
    .BLINK_FRAMES      (120),
    .BLINK_PERIOD_LOG2 (3),
    .SHATTER_FRAMES    (240)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [3:0] lives;
    logic       vis;
    logic       frag;
    logic       shat;
    logic       go;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_out(input string name, input logic [1:0] st, input logic [3:0] lives,
                            input logic vis, input logic frag, input logic shat, input logic go);
    exp_t e;
    e.name = name; e.st = st; e.lives = lives;
    e.vis = vis; e.frag = frag; e.shat = shat; e.go = go;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    step();
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd3;
  endtask

  task automatic hit_pulse();
    bus.hit_in = 1'b1;
    step();
    bus.hit_in = 1'b0;
    step();
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (bus.state_out === mon_e.st && bus.lives_out === mon_e.lives &&
          bus.heart_visible_out === mon_e.vis && bus.frag_rst_out === mon_e.frag &&
          bus.shatter_active_out === mon_e.shat && bus.game_over_out === mon_e.go) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got st=%0d lives=%0d vis=%b frag=%b shat=%b go=%b, want st=%0d lives=%0d vis=%b frag=%b shat=%b go=%b",
                 mon_e.name, bus.state_out, bus.lives_out, bus.heart_visible_out, bus.frag_rst_out,
                 bus.shatter_active_out, bus.game_over_out, mon_e.st, mon_e.lives, mon_e.vis,
                 mon_e.frag, mon_e.shat, mon_e.go);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.valid_in   = 1'b1;
    bus.hcount_in  = 11'd5;
    bus.vcount_in  = 10'd3;
    bus.hit_in     = 1'b0;
    bus.restart_in = 1'b0;
    step();
    step();
    expect_out("reset", 2'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Level-held hit: exactly one decrement.
    bus.hit_in = 1'b1;
    step();
    expect_out("hit_rise", 2'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (49) step();
    expect_out("hit_held", 2'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.hit_in = 1'b0;
    step();

    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_out("blink_vis", 2'd1, 4'd2, (((i >> 3) & 1) == 0), 1'b1, 1'b0, 1'b0);
    end
    hit_pulse();
    expect_out("blink_hit_ignored", 2'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Frozen with valid low: the remaining tick count to exit must be unchanged.
    bus.valid_in = 1'b0;
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    repeat (1000) step();
    expect_out("blink_frozen", 2'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.valid_in = 1'b1;
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd3;

    for (int i = 11; i <= 119; i++) begin
      tick();
      expect_out("blink_vis", 2'd1, 4'd2, (((i >> 3) & 1) == 0), 1'b1, 1'b0, 1'b0);
    end
    tick();
    expect_out("blink_end", 2'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    hit_pulse();
    expect_out("hit2", 2'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (120) tick();
    expect_out("blink2_end", 2'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Final hit coincides with a frame tick: hit wins, counter starts from zero.
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd0;
    bus.hit_in    = 1'b1;
    step();
    bus.hcount_in = 11'd5;
    bus.vcount_in = 10'd3;
    bus.hit_in    = 1'b0;
    expect_out("final_hit", 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    hit_pulse();
    expect_out("shatter_hit_ignored", 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (239) tick();
    expect_out("shatter_last", 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("game_over", 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    hit_pulse();
    repeat (3) tick();
    expect_out("game_over_hold", 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    bus.restart_in = 1'b1;
    bus.hit_in     = 1'b1;
    step();
    bus.restart_in = 1'b0;
    bus.hit_in     = 1'b0;
    expect_out("restart_over_hit", 2'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    hit_pulse();
    expect_out("hit_after_restart", 2'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (120) tick();
    hit_pulse();
    expect_out("hit_b", 2'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (120) tick();
    hit_pulse();
    expect_out("shatter_b", 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (100) tick();
    expect_out("shatter_100", 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("rst_mid_shatter", 2'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    hit_pulse();
    repeat (3) tick();
    expect_out("blink_c", 2'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.hcount_in  = 11'd0;
    bus.vcount_in  = 10'd0;
    bus.restart_in = 1'b1;
    step();
    bus.restart_in = 1'b0;
    bus.hcount_in  = 11'd5;
    bus.vcount_in  = 10'd3;
    expect_out("restart_in_blink", 2'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    step();
    step();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/heart_life_sequencer.md
Name: heart_life_sequencer

Overview:
Game-level controller directly upstream of the heart fragment-animation stage. Tracks remaining lives, blinks the intact heart during post-hit invulnerability, and on the final hit releases the fragment stage's reset so the shatter animation plays for a fixed number of frames. After the animation it raises game-over. All timing is counted in video frames derived from the same hcount/vcount/valid stream the fragment stage uses.

Parameters:
LIVES, 3, lives at reset/restart; legal range 1..15
BLINK_FRAMES, 120, invulnerability duration in frames; legal range 1..1023
BLINK_PERIOD_LOG2, 3, heart visibility toggles every 2^BLINK_PERIOD_LOG2 frames
SHATTER_FRAMES, 240, shatter animation duration in frames; legal range 1..1023

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
hcount_in  in  11  pixel column
vcount_in  in  10  pixel row
valid_in  in  1  hcount/vcount valid
hit_in  in  1  collision level from the hit detector; may stay high for many pixels
restart_in  in  1  single-cycle new-game request
frag_rst_out  out  1  drives the fragment stage's rst; high holds fragments at centre
heart_visible_out  out  1  enables the intact-heart sprite
shatter_active_out  out  1  high while fragments animate
lives_out  out  4  remaining lives
game_over_out  out  1  high once the shatter animation completes
state_out  out  2  current FSM state, for debug and the HUD

Behaviour:
- Clock and reset: reset is rst, synchronous, active-high; clock is clk.
- Reset values: state ALIVE, lives_out=LIVES, heart_visible_out=1, frag_rst_out=1, shatter_active_out=0, game_over_out=0, frame_cnt=0, hit_q=0.
- Frame tick: frame_tick = valid_in && hcount_in==0 && vcount_in==0. It is combinational and used in the same cycle.
- Hit edge: hit_rise = hit_in && !hit_q, where hit_q is hit_in registered every cycle. Only hit_rise counts as a hit.
- All outputs are registered. An event sampled in cycle t is reflected on the outputs in cycle t+1.
- Hits and restart are ignored outside ALIVE and GAME_OVER except as listed below.
- States (2-bit encoding): ALIVE=0, BLINK=1, SHATTER=2, GAME_OVER=3.
- ALIVE:
  - heart visible, frag_rst=1.
  - On hit_rise with lives>1: lives-1, frame_cnt<=0, go to BLINK.
  - On hit_rise with lives==1: lives<=0, frame_cnt<=0, frag_rst<=0, heart_visible<=0, shatter_active<=1, go to SHATTER.
- BLINK:
  - frag_rst=1. hit_rise is ignored (invulnerable).
  - frame_cnt increments on each frame_tick.
  - heart_visible = (frame_cnt >> BLINK_PERIOD_LOG2) bit0 == 0, so the heart is visible for frame_cnt 0..2^N-1, then hidden for the next 2^N frames, and so on.
  - When frame_tick arrives with frame_cnt==BLINK_FRAMES-1: go to ALIVE, heart_visible=1, frame_cnt=0.
- SHATTER:
  - frag_rst=0, heart hidden, shatter_active=1. hit_rise is ignored.
  - frame_cnt increments on frame_tick.
  - When frame_tick arrives with frame_cnt==SHATTER_FRAMES-1: go to GAME_OVER, shatter_active=0, game_over=1.
- GAME_OVER:
  - frag_rst stays 0, so fragments remain where they finished (off-screen or clamped).
  - heart hidden, game_over=1. Waits for restart_in.
- restart_in, from any state:
  - state ALIVE, lives=LIVES, frame_cnt=0, frag_rst=1, heart_visible=1, shatter_active=0, game_over=0.
  - restart_in has priority over a simultaneous hit_rise or frame_tick.
- Simultaneous hit_rise and frame_tick in ALIVE: the hit wins; frame_cnt is forced to 0, not incremented.
- frame_cnt is 10 bits and never wraps in legal configurations; it is cleared on every state entry.
- rst in any state, including mid-shatter, returns all registers to their reset values in the next cycle.
- When valid_in stays low, no frame_tick occurs and BLINK/SHATTER are frozen; hit handling continues.

Decomposition:
- Package heart_seq_pkg holds:
  - typedef enum logic[1:0] {ALIVE, BLINK, SHATTER, GAME_OVER} heart_state_t
  - constant FRAME_CNT_W=10
- Sub-module frame_tick_gen: inputs hcount_in, vcount_in, valid_in; output frame_tick. It is shared with other frame-stepped sprite blocks.

Test Plan:
- Reset -> lives_out=3, state_out=0, frag_rst_out=1, heart_visible_out=1, game_over_out=0.
- Hold hit_in high for 50 cycles in ALIVE -> exactly one decrement; lives_out=2 and state_out=1 one cycle after the rising edge.
- In BLINK, step 16 frames with BLINK_PERIOD_LOG2=3 -> heart visible for frames 0..7, hidden for 8..15. A hit pulse in BLINK leaves lives_out=2. After 120 ticks, state_out=0.
- Three separated hits -> after the third, lives_out=0, state_out=2, frag_rst_out=0, shatter_active_out=1. After 240 ticks: state_out=3, game_over_out=1, frag_rst_out still 0.
- restart_in with hit_rise in the same cycle during GAME_OVER -> next cycle state_out=0, lives_out=3, frag_rst_out=1, game_over_out=0.
- rst asserted mid-SHATTER at frame 100 -> next cycle all outputs at reset values. valid_in held low for 1000 cycles in BLINK -> frame_cnt unchanged.
